regfile_dump: RTL
=================

# regfile_dump

Sequential read-back engine for the 32 x 32-bit register file. On a start pulse it walks every register through one read port and captures each word. It then shows the word one byte at a time on the 8 board LEDs, holding each byte for a programmable dwell. It also accumulates an XOR checksum of all words read. It sits on the read-port side of the register file, opposite the switch-driven write path, and replaces manual Addr/Opt stepping for bulk verification of register contents.

## Interface
- NREG, 32: number of registers dumped, addresses 0..NREG-1.
- AW, 5: address width.
- DWELL, 4: clock cycles each byte is held on LED; must be >= 1.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- Hold  in  1  while high, freezes the dwell counter in SHOW.
- R_Addr  out  AW  read address to register-file port A.
- R_Data  in  32  combinational read data from port A.
- LED  out  8  currently displayed byte.
- Byte_Sel  out  2  index of displayed byte: 0 = [7:0] … 3 = [31:24].
- Busy  out  1  high from FETCH of register 0 through the last SHOW cycle.
- Done  out  1  one-cycle pulse on dump completion.
- Sum  out  32  XOR of all words captured in the current or last dump.

## Operation
- States: IDLE, FETCH, SHOW, DONE.
- IDLE: Start=1 clears Sum, LED, Byte_Sel, address and dwell count to 0, then goes to FETCH. Start=0 stays in IDLE.
- FETCH (1 cycle): drives R_Addr = current address. At the closing edge it captures R_Data into the word register, sets Sum ^= R_Data, resets Byte_Sel and the dwell count to 0, and goes to SHOW.
- SHOW: LED = word byte[Byte_Sel].
  - The dwell count increments each cycle while Hold=0.
  - At count DWELL-1 with Hold=0, the count returns to 0, then:
    - Byte_Sel<3: Byte_Sel++.
    - Byte_Sel=3 and address<NREG-1: address++, go to FETCH.
    - Byte_Sel=3 and address=NREG-1: go to DONE.
- DONE (1 cycle): Done=1, then IDLE.
- Outputs after a completed dump, held in IDLE until the next Start:
  - LED = byte 3 of the last word.
  - Sum = final checksum.
  - R_Addr = NREG-1.
- Start outside IDLE is ignored, including a Start in the DONE cycle.
- Hold has no effect in IDLE, FETCH or DONE.
- The address never wraps; the dump ends at NREG-1.

## Timing
- Reset: state IDLE; R_Addr=0, LED=0, Byte_Sel=0, Busy=0, Done=0, Sum=0; internal word register and counters 0.
- Reset mid-dump aborts at the next edge and applies the reset values above. No Done is issued.
- Start high in cycle 0 places FETCH of register 0 in cycle 1. Byte 0 is on LED from cycle 2.
- Each register costs 1 + 4*DWELL cycles with Hold=0. Each Hold cycle in SHOW adds exactly one cycle.
- With Hold=0, DONE (Done=1) falls in cycle 1 + NREG*(1+4*DWELL). Busy is low in that cycle.
- LED, Byte_Sel, Busy, Done and Sum are registered outputs. R_Addr is registered from the address counter.
- R_Data must be stable during FETCH; the register file is read asynchronously.

## Structure
- Package regfile_dump_pkg holds:
  - the state enum (IDLE, FETCH, SHOW, DONE);
  - byte-index constants BYTE0..BYTE3;
  - the default NREG, AW and DWELL values shared with the register-file top.
- One sub-module, dump_dwell_counter.
  - Parameter DWELL.
  - Inputs Clk, Reset, clear, enable.
  - Output wrap, high on the cycle where count = DWELL-1 with enable=1.
- FSM, address counter, byte index, word register and checksum live in regfile_dump.

## Test plan
- Reset values: assert Reset for 2 cycles. Required: all outputs 0 and Busy=0. Start held low for 10 cycles leaves them unchanged.
- Basic dump: NREG=32, DWELL=2. Register 1 = 32'hf0f0_f0f0, register 5 = 32'h0f0f_0f00, all others 0. Pulse Start in cycle 0.
  - LED = 8'hf0 for cycles 11..18.
  - LED for register 5 reads 00, 0f, 0f, 0f, two cycles each.
  - Done in cycle 289.
  - Sum = 32'hffff_ff f0 is wrong; required Sum = 32'hffff_fff0.
- Hold: DWELL=2, assert Hold for 5 cycles during byte 2 of register 0. Required: LED and Byte_Sel frozen for those cycles; Done shifts to cycle 294.
- Start while busy: pulse Start again in cycles 50 and 289. Required: no restart, Sum not cleared, Done still in cycle 289 and only once.
- Reset mid-dump: assert Reset in cycle 100. Required: in cycle 101 all outputs are 0 and the state is IDLE. A new Start then completes a full dump with a correct Sum.
- Full-word boundary: all 32 registers = 32'hffff_ffff. Required: Sum = 0 and every LED byte = 8'hff. Final R_Addr = 31 with no wrap to 0.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared types and defaults for the register-file dump engine
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] BYTE0 = 2'd0;
  localparam logic [1:0] BYTE1 = 2'd1;
  localparam logic [1:0] BYTE2 = 2'd2;
  localparam logic [1:0] BYTE3 = 2'd3;

  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int DWELL_DEF = 4;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      BYTE0:   return w[7:0];
      BYTE1:   return w[15:8];
      BYTE2:   return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - control, read-port and display signals of the dump engine
interface regfile_dump_if #(
  parameter int AW = 5
);
  logic          start;
  logic          hold;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic [7:0]    led;
  logic [1:0]    byte_sel;
  logic          busy;
  logic          done;
  logic [31:0]   sum;

  modport master (
    output start, hold, r_data,
    input  r_addr, led, byte_sel, busy, done, sum
  );

  modport slave (
    input  start, hold, r_data,
    output r_addr, led, byte_sel, busy, done, sum
  );
endinterface

// File: rtl/regfile_dump_dwell_counter.sv
// rtl/regfile_dump_dwell_counter.sv - per-byte dwell timer with clear and freeze
module dump_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic wrap_o
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q, count_d;

  assign wrap_o = enable_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks every register, shows each word bytewise on LEDs, XORs a checksum
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic           clk_i,
  input  logic           reset_i,
  regfile_dump_if.slave  bus
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   word_q;
  logic [31:0]   sum_q;
  logic [7:0]    led_q;
  logic [1:0]    byte_sel_q;
  logic          busy_q;
  logic          done_q;

  logic dwell_clear, dwell_enable, dwell_wrap;

  assign dwell_clear  = ((state_q == ST_IDLE) && bus.start) || (state_q == ST_FETCH);
  assign dwell_enable = (state_q == ST_SHOW) && !bus.hold;

  dump_dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (dwell_clear),
    .enable_i(dwell_enable),
    .wrap_o  (dwell_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      led_q      <= '0;
      byte_sel_q <= BYTE0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sum_q      <= '0;
            led_q      <= '0;
            byte_sel_q <= BYTE0;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // LED is registered, so byte 0 is loaded straight from the read port
          word_q     <= bus.r_data;
          sum_q      <= sum_q ^ bus.r_data;
          byte_sel_q <= BYTE0;
          led_q      <= bus.r_data[7:0];
          state_q    <= ST_SHOW;
        end
        ST_SHOW: begin
          if (dwell_wrap) begin
            if (byte_sel_q != BYTE3) begin
              byte_sel_q <= byte_sel_q + 2'd1;
              led_q      <= byte_of(word_q, byte_sel_q + 2'd1);
            end else if (addr_q != LAST_ADDR) begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.r_addr   = addr_q;
  assign bus.led      = led_q;
  assign bus.byte_sel = byte_sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
endmodule
